// File: rtl/sdram_read_ppfifo.sv
`default_nettype none
// ============================================================================
// Module   : sdram_read_ppfifo
// Brief    : Two-bank ping-pong buffer between the SDRAM read engine and the
//            Wishbone-side reader, with commit-order queue and status flags.
// Revision : 1.0
// ============================================================================
module sdram_read_ppfifo #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_reset,
    output logic [1:0]            write_ready,
    input  logic [1:0]            write_activate,
    output logic [23:0]           write_fifo_size,
    input  logic                  write_strobe,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  starved,
    output logic                  read_ready,
    input  logic                  read_activate,
    output logic [23:0]           read_count,
    input  logic                  read_strobe,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] c_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_EMPTY     = 2'd0,
        S_WRITING   = 2'd1,
        S_COMMITTED = 2'd2,
        S_READING   = 2'd3
    } bank_state_t;

    bank_state_t            r_state     [2];
    bank_state_t            w_state_nxt [2];
    logic [ADDR_WIDTH:0]    r_count     [2];
    logic [ADDR_WIDTH:0]    w_count_nxt [2];
    logic [1:0]             w_commit;

    logic [1:0]             r_wact_prev;
    logic                   r_ract_prev;
    logic                   r_q         [2];
    logic [1:0]             r_q_cnt;
    logic                   r_rd_bank;
    logic [ADDR_WIDTH:0]    r_rptr;
    logic [ADDR_WIDTH:0]    r_read_cnt;
    logic [DATA_WIDTH-1:0]  r_read_data;
    logic [DATA_WIDTH-1:0]  r_mem [0:(2*(1<<ADDR_WIDTH))-1];
    logic [1:0]             r_write_ready;
    logic                   r_read_ready;
    logic                   r_starved;
    logic                   r_overflow;
    logic                   r_underflow;

    logic                   w_wact_legal;
    logic                   w_wr_any;
    logic                   w_wr_bank;
    logic                   w_wr_full;
    logic                   w_wr_do;
    logic [ADDR_WIDTH:0]    w_wr_addr;
    logic                   w_rd_reading;
    logic                   w_rd_do;
    logic                   w_rd_release;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_any_reading;

    always_comb begin
        w_wact_legal  = (write_activate != 2'b11);
        w_wr_any      = (r_state[0] == S_WRITING) || (r_state[1] == S_WRITING);
        w_wr_bank     = (r_state[1] == S_WRITING);
        w_wr_full     = (r_count[w_wr_bank] == c_FULL);
        w_wr_do       = write_strobe && !write_reset && w_wr_any && !w_wr_full;
        w_wr_addr     = {w_wr_bank, r_count[w_wr_bank][ADDR_WIDTH-1:0]};
        w_rd_reading  = (r_state[r_rd_bank] == S_READING);
        w_rd_do       = read_strobe && w_rd_reading && (r_rptr < r_read_cnt);
        w_rd_release  = !read_activate && r_ract_prev && w_rd_reading;
        w_pop         = read_activate && !r_ract_prev && r_read_ready && (r_q_cnt != 2'd0);
        w_any_reading = (r_state[0] == S_READING) || (r_state[1] == S_READING);

        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            w_count_nxt[i] = r_count[i];
            w_commit[i]    = 1'b0;
            case (r_state[i])
                S_EMPTY: begin
                    if (write_activate[i] && !r_wact_prev[i] && w_wact_legal)
                        w_state_nxt[i] = S_WRITING;
                end
                S_WRITING: begin
                    if (write_reset)
                        w_count_nxt[i] = '0;
                    else if (w_wr_do && (w_wr_bank == 1'(i)))
                        w_count_nxt[i] = r_count[i] + 1'b1;
                    if (!write_activate[i] && r_wact_prev[i]) begin
                        // An empty release hands the bank straight back to the writer.
                        if (w_count_nxt[i] != '0) begin
                            w_state_nxt[i] = S_COMMITTED;
                            w_commit[i]    = 1'b1;
                        end else begin
                            w_state_nxt[i] = S_EMPTY;
                        end
                    end
                end
                S_COMMITTED: begin
                    if (w_pop && (r_q[0] == 1'(i)))
                        w_state_nxt[i] = S_READING;
                end
                S_READING: begin
                    if (!read_activate && r_ract_prev) begin
                        w_state_nxt[i] = S_EMPTY;
                        w_count_nxt[i] = '0;
                    end
                end
                default: w_state_nxt[i] = S_EMPTY;
            endcase
        end
        w_push = |w_commit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= S_EMPTY;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_count[i] <= w_count_nxt[i];
            end
        end
    end

    // Commit-order queue; a simultaneous push and pop keeps occupancy fixed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q[0]  <= 1'b0;
            r_q[1]  <= 1'b0;
            r_q_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_q[r_q_cnt[0]] <= w_commit[1];
                    r_q_cnt         <= r_q_cnt + 2'd1;
                end
                2'b01: begin
                    r_q[0]  <= r_q[1];
                    r_q_cnt <= r_q_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_q_cnt == 2'd2) begin
                        r_q[0] <= r_q[1];
                        r_q[1] <= w_commit[1];
                    end else begin
                        r_q[0] <= w_commit[1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wact_prev   <= 2'b00;
            r_ract_prev   <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_rptr        <= '0;
            r_read_cnt    <= '0;
            r_read_data   <= '0;
            r_write_ready <= 2'b11;
            r_read_ready  <= 1'b0;
            r_starved     <= 1'b1;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_wact_prev <= write_activate;
            r_ract_prev <= read_activate;
            if (w_pop) begin
                r_rd_bank  <= r_q[0];
                r_read_cnt <= r_count[r_q[0]];
                r_rptr     <= '0;
            end else if (w_rd_release) begin
                r_read_cnt <= '0;
                r_rptr     <= '0;
            end else if (w_rd_do) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_rd_do)
                r_read_data <= r_mem[{r_rd_bank, r_rptr[ADDR_WIDTH-1:0]}];
            for (int i = 0; i < 2; i++)
                r_write_ready[i] <= (r_state[i] == S_EMPTY) && !write_activate[i];
            r_read_ready <= (r_q_cnt != 2'd0) && !read_activate;
            r_starved    <= (r_q_cnt == 2'd0) && !w_any_reading;
            if (write_strobe && (!w_wr_any || (w_wr_full && !write_reset)))
                r_overflow <= 1'b1;
            if (read_strobe && !w_rd_do)
                r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_do)
            r_mem[w_wr_addr] <= write_data;
    end

    assign write_ready     = r_write_ready;
    assign write_fifo_size = 24'(c_FULL);
    assign starved         = r_starved;
    assign read_ready      = r_read_ready;
    assign read_count      = 24'(r_read_cnt);
    assign read_data       = r_read_data;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

endmodule
`default_nettype wire
